// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: generates the register enables and
// bubble requests, sequences the boot delay and the halt drain, and counts stalls and flushes.
module pipeline_ctrl #(
  parameter int unsigned BOOT_CYCLES = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             imem_valid,
  input  logic             dmem_busy,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             halt_req,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             bubble_ifid,
  output logic             bubble_idex,
  output logic [1:0]       state_o,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_INIT = BW'(BOOT_CYCLES - 1);
  localparam logic [1:0]    DRAIN_INIT = 2'd3;

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    DRAIN  = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [BW-1:0]    r_boot_cnt;
  logic [BW-1:0]    w_boot_next;
  logic [1:0]       r_drain_cnt;
  logic [1:0]       w_drain_next;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_inc;
  logic             w_flush_inc;

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= BOOT;
      r_boot_cnt  <= BOOT_INIT;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_next;
      r_boot_cnt  <= w_boot_next;
      r_drain_cnt <= w_drain_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_boot_next  = r_boot_cnt;
    w_drain_next = r_drain_cnt;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;
    en_pc        = 1'b0;
    en_ifid      = 1'b0;
    en_idex      = 1'b0;
    en_exmem     = 1'b0;
    en_memwb     = 1'b0;
    bubble_ifid  = 1'b0;
    bubble_idex  = 1'b0;

    unique case (r_state)
      BOOT: begin
        if (r_boot_cnt == '0) w_state_next = RUN;
        else                  w_boot_next  = r_boot_cnt - 1'b1;
      end

      RUN: begin
        // Priority order matters: a frozen EX holds branch_taken, so the redirect
        // is taken on the first unfrozen cycle.
        if (dmem_busy) begin
          w_stall_inc = 1'b1;
        end else if (branch_taken) begin
          en_pc       = 1'b1;
          en_ifid     = 1'b1;
          en_idex     = 1'b1;
          en_exmem    = 1'b1;
          en_memwb    = 1'b1;
          bubble_ifid = 1'b1;
          bubble_idex = 1'b1;
          w_flush_inc = 1'b1;
        end else if (load_use) begin
          en_idex     = 1'b1;
          en_exmem    = 1'b1;
          en_memwb    = 1'b1;
          bubble_idex = 1'b1;
          w_stall_inc = 1'b1;
        end else if (halt_req) begin
          en_ifid      = 1'b1;
          en_idex      = 1'b1;
          en_exmem     = 1'b1;
          en_memwb     = 1'b1;
          bubble_ifid  = 1'b1;
          w_state_next = DRAIN;
          w_drain_next = DRAIN_INIT;
        end else if (!imem_valid) begin
          en_ifid     = 1'b1;
          en_idex     = 1'b1;
          en_exmem    = 1'b1;
          en_memwb    = 1'b1;
          bubble_ifid = 1'b1;
          w_stall_inc = 1'b1;
        end else begin
          en_pc    = 1'b1;
          en_ifid  = 1'b1;
          en_idex  = 1'b1;
          en_exmem = 1'b1;
          en_memwb = 1'b1;
        end
      end

      DRAIN: begin
        if (dmem_busy) begin
          w_stall_inc = 1'b1;
        end else begin
          en_ifid     = 1'b1;
          en_idex     = 1'b1;
          en_exmem    = 1'b1;
          en_memwb    = 1'b1;
          bubble_ifid = 1'b1;
          bubble_idex = 1'b1;
          if (r_drain_cnt == '0) w_state_next = HALTED;
          else                   w_drain_next = r_drain_cnt - 1'b1;
        end
      end

      HALTED: begin
      end

      default: begin
        w_state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign state_o   = r_state;
  assign halted    = (r_state == HALTED);
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RISC-V lite core. It drives the ENABLE inputs of the PC register and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB), plus bubble (squash-to-NOP) requests for IF/ID and ID/EX. Its inputs are hazard and memory-handshake signals. It also sequences the post-reset boot delay, drains the pipeline on a halt request, and keeps saturating stall/flush performance counters.

## Interface
- BOOT_CYCLES, 4, cycles after reset release before the pipeline is enabled; legal values are 1 and above.
- CNT_W, 32, width of each performance counter.

- CK  in  1  clock, rising edge.
- RESET  in  1  reset; asynchronous, active-low.
- imem_valid  in  1  instruction fetch data is valid this cycle.
- dmem_busy  in  1  MEM-stage data access is still outstanding.
- load_use  in  1  load-use hazard detected on the instruction in ID.
- branch_taken  in  1  EX stage resolved a taken branch or jump.
- halt_req  in  1  ecall/ebreak decoded in ID; held while that instruction sits in ID.
- en_pc, en_ifid, en_idex, en_exmem, en_memwb  out  1 each  register enables.
- bubble_ifid, bubble_idex  out  1 each  the enabled register loads a NOP instead of its data; asserted only together with the matching enable.
- state_o  out  2  BOOT=00, RUN=01, DRAIN=10, HALTED=11.
- halted  out  1  1 when in HALTED.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- Enables and bubbles are combinational functions of the registered state and the current inputs. The state, boot/drain counters and perf counters are registered.
- **BOOT**
  - All enables and bubbles are 0.
  - The boot counter loads BOOT_CYCLES-1 at reset and decrements each cycle.
  - When it is 0, go to RUN on the next edge.
- **RUN**, first matching rule wins:
  1. dmem_busy=1: all enables 0, no bubbles (full freeze); stall_cnt+1.
  2. branch_taken=1: all enables 1, bubble_ifid=1, bubble_idex=1; flush_cnt+1. load_use and halt_req are ignored.
  3. load_use=1: en_pc=0, en_ifid=0, others 1, bubble_idex=1; stall_cnt+1.
  4. halt_req=1: en_pc=0, others 1, bubble_ifid=1. Go to DRAIN with the drain counter loaded to 3.
  5. imem_valid=0: en_pc=0, others 1, bubble_ifid=1; stall_cnt+1.
  6. Otherwise all enables 1, no bubbles.
- **DRAIN**
  - dmem_busy=1: full freeze, the drain counter holds, stall_cnt+1.
  - Otherwise: en_pc=0, en_ifid/idex/exmem/memwb=1, bubble_ifid=1, bubble_idex=1, and the drain counter decrements.
  - When the counter is 0 on an unfrozen cycle, go to HALTED.
  - branch_taken, load_use, halt_req and imem_valid are ignored.
- **HALTED**
  - All enables 0, halted=1.
  - The only exit is RESET.
- **Counters**
  - Increment at most 1 per cycle.
  - Saturate at all-ones.
  - Updated values are visible the cycle after the event.

## Timing
- Reset (async assert, any state including mid-DRAIN): state=BOOT, boot counter=BOOT_CYCLES-1. Outputs: enables 0, bubbles 0, stall_cnt=0, flush_cnt=0, halted=0, state_o=00.
- The first cycle with en_pc=1 is cycle BOOT_CYCLES, counting cycle 0 as the first rising edge after RESET deasserts.
- Enable/bubble latency is 0 cycles: outputs respond in the same cycle as their inputs.
- The halting instruction reaches WB and retires before HALTED. From the halt_req accept edge, DRAIN lasts exactly 4 unfrozen cycles.
- branch_taken together with dmem_busy: freeze wins. The redirect applies on the first cycle dmem_busy=0, provided branch_taken is still high (EX is frozen, so it holds).
- load_use together with imem_valid=0: the load_use rule applies, and IF/ID holds its old content.

## Test plan
- Boot timing: BOOT_CYCLES=4, release RESET → state_o=00 and all enables 0 for cycles 0-3; at cycle 4 state_o=01 and all enables 1.
- Load-use: in RUN, load_use=1 for 1 cycle → en_pc=0, en_ifid=0, en_idex=1, bubble_idex=1, other enables 1; stall_cnt goes 0→1.
- Branch vs freeze: branch_taken=1 and dmem_busy=1 for 3 cycles, then dmem_busy=0 → 3 freeze cycles with stall_cnt=3; next cycle all enables 1 with both bubbles set; flush_cnt=1.
- Fetch miss: imem_valid=0 for 2 cycles → en_pc=0, bubble_ifid=1, back-end enables 1; stall_cnt=2.
- Halt drain: halt_req=1, with dmem_busy=1 for 2 cycles during DRAIN → state 10 for 6 cycles; then state 11, halted=1, all enables 0. Later inputs have no effect.
- Saturation/reset: CNT_W=4, 20 stall cycles → stall_cnt=15. Assert RESET mid-DRAIN → state_o=00, counters 0, halted=0 immediately, with no clock edge needed.
